// File: rtl/square_motion_ctrl.sv
// square_motion_ctrl
// Synchronises and debounces four active-low push-buttons and moves the
// on-screen square once per frame, in vertical blanking. The square's
// top-left corner is clamped so the whole square stays on the panel.
//
// Frame sequencing (state is internal, signal "state"):
//   S_ACTIVE -> S_UPDATE on the 1->0 edge of i_vde
//   S_UPDATE -> S_BLANK  after one cycle (positions committed here)
//   S_BLANK  -> S_ACTIVE once i_vde returns to 1
module square_motion_ctrl #(
    parameter int H_RES     = 800,
    parameter int V_RES     = 480,
    parameter int SQ_SIZE   = 40,
    parameter int STEP      = 4,
    parameter int X_INIT    = 380,
    parameter int Y_INIT    = 220,
    parameter int DB_CYCLES = 33000,
    parameter int DB_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vde,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_up,
    input  logic       i_down,
    output logic [9:0] o_sq_x,
    output logic [9:0] o_sq_y,
    output logic       o_update,
    output logic       o_moving
);

    localparam logic [1:0] S_ACTIVE = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_BLANK  = 2'd2;

    // 11-bit limits so add/subtract can never wrap the 10-bit positions
    localparam logic [10:0]     X_MAX   = 11'(H_RES - SQ_SIZE);
    localparam logic [10:0]     Y_MAX   = 11'(V_RES - SQ_SIZE);
    localparam logic [10:0]     STEP_V  = 11'(STEP);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Button vectors: bit 0 left, 1 right, 2 up, 3 down; 1 = released
    logic [3:0]      btn_raw;
    logic [3:0]      sync_a;
    logic [3:0]      sync_b;
    logic [3:0]      btn_deb;
    logic [DB_W-1:0] db_cnt [4];

    logic        vde_q;
    logic        fall;
    logic [1:0]  state;
    logic        pr_left, pr_right, pr_up, pr_down;
    logic [10:0] x_ext, y_ext, x_inc, y_inc;
    logic [9:0]  next_x, next_y;

    assign btn_raw  = {i_down, i_up, i_right, i_left};
    assign pr_left  = ~btn_deb[0];
    assign pr_right = ~btn_deb[1];
    assign pr_up    = ~btn_deb[2];
    assign pr_down  = ~btn_deb[3];
    assign fall     = vde_q & ~i_vde;

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_a <= 4'hf;
            sync_b <= 4'hf;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Per-button debounce: accept a change after DB_CYCLES stable mismatching cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_deb <= 4'hf;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == btn_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_deb[i] <= sync_b[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // One-cycle delayed vde for falling-edge detection; reset low so no false tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vde_q <= 1'b0;
        else          vde_q <= i_vde;
    end

    // Next position with clamping; opposing buttons cancel
    always_comb begin
        x_ext  = {1'b0, o_sq_x};
        y_ext  = {1'b0, o_sq_y};
        x_inc  = x_ext + STEP_V;
        y_inc  = y_ext + STEP_V;
        next_x = o_sq_x;
        next_y = o_sq_y;
        if (pr_left && !pr_right)
            next_x = (x_ext >= STEP_V) ? 10'(x_ext - STEP_V) : 10'd0;
        else if (pr_right && !pr_left)
            next_x = (x_inc <= X_MAX) ? 10'(x_inc) : 10'(X_MAX);
        if (pr_up && !pr_down)
            next_y = (y_ext >= STEP_V) ? 10'(y_ext - STEP_V) : 10'd0;
        else if (pr_down && !pr_up)
            next_y = (y_inc <= Y_MAX) ? 10'(y_inc) : 10'(Y_MAX);
    end

    // Frame FSM; positions, update pulse and moving flag load only in S_UPDATE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_ACTIVE;
            o_sq_x   <= 10'(X_INIT);
            o_sq_y   <= 10'(Y_INIT);
            o_update <= 1'b0;
            o_moving <= 1'b0;
        end else begin
            o_update <= 1'b0;
            case (state)
                S_ACTIVE: if (fall) state <= S_UPDATE;
                S_UPDATE: begin
                    o_sq_x   <= next_x;
                    o_sq_y   <= next_y;
                    o_update <= 1'b1;
                    o_moving <= (next_x != o_sq_x) || (next_y != o_sq_y);
                    state    <= S_BLANK;
                end
                S_BLANK:  if (i_vde) state <= S_ACTIVE;
                default:  state <= S_ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Bench for square_motion_ctrl: two instances (A from the default start
// position, B starting near the left edge with its own button), a
// window-based behavioural model checked every cycle, plus literal pins.
module tb_square_motion_ctrl;

    localparam int DB   = 4;
    localparam int STP  = 4;
    localparam int XMAX = 760;
    localparam int YMAX = 440;

    logic clk = 1'b0;
    logic rst_n, vde, left, right, up, down, b_left;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic upd_a, mov_a, upd_b, mov_b;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;

    square_motion_ctrl #(.STEP(STP), .X_INIT(380), .Y_INIT(220), .DB_CYCLES(DB), .DB_W(3)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_vde(vde), .i_left(left), .i_right(right),
        .i_up(up), .i_down(down), .o_sq_x(x_a), .o_sq_y(y_a), .o_update(upd_a), .o_moving(mov_a));

    square_motion_ctrl #(.STEP(STP), .X_INIT(2), .Y_INIT(2), .DB_CYCLES(DB), .DB_W(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_vde(vde), .i_left(b_left), .i_right(1'b1),
        .i_up(1'b1), .i_down(1'b1), .o_sq_x(x_b), .o_sq_y(y_b), .o_update(upd_b), .o_moving(mov_b));

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic frame(input int act, input int blk);
        vde = 1'b1;
        tick(act);
        vde = 1'b0;
        tick(blk);
    endtask

    // ---------------- behavioural model ----------------
    bit c_rst = 1'b0;
    bit c_vde = 1'b0;
    bit c_raw [2][4];
    int mx [2];
    int my [2];
    bit mupd [2];
    bit mmov [2];
    bit mdeb [2][4];             // 1 = released
    bit hist [2][4][DB+2];       // raw samples, [0] newest
    bit mvq, mpend;
    int px [2];
    int py [2];

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            mx[u] = (u == 0) ? 380 : 2;
            my[u] = (u == 0) ? 220 : 2;
            mupd[u] = 1'b0;
            mmov[u] = 1'b0;
            for (int b = 0; b < 4; b++) begin
                mdeb[u][b] = 1'b1;
                for (int j = 0; j < DB + 2; j++) hist[u][b][j] = 1'b1;
            end
        end
        mvq = 1'b0;
        mpend = 1'b0;
    endtask

    // One clock edge: move on a pending frame tick, then track the buttons.
    // A button is accepted once its synchronised value (raw, two edges old)
    // has disagreed with the accepted value on DB consecutive edges.
    task automatic model_step();
        int dx, dy, nx, ny;
        bit flip;
        for (int u = 0; u < 2; u++) begin
            mupd[u] = mpend;
            if (mpend) begin
                dx = 0;
                dy = 0;
                if (!mdeb[u][0] && mdeb[u][1]) dx = -STP;
                if (!mdeb[u][1] && mdeb[u][0]) dx = STP;
                if (!mdeb[u][2] && mdeb[u][3]) dy = -STP;
                if (!mdeb[u][3] && mdeb[u][2]) dy = STP;
                nx = clampi(mx[u] + dx, XMAX);
                ny = clampi(my[u] + dy, YMAX);
                mmov[u] = (nx != mx[u]) || (ny != my[u]);
                mx[u] = nx;
                my[u] = ny;
            end
            for (int b = 0; b < 4; b++) begin
                for (int j = DB + 1; j > 0; j--) hist[u][b][j] = hist[u][b][j-1];
                hist[u][b][0] = c_raw[u][b];
                flip = 1'b1;
                for (int j = 2; j < DB + 2; j++)
                    if (hist[u][b][j] == mdeb[u][b]) flip = 1'b0;
                if (flip) mdeb[u][b] = ~mdeb[u][b];
            end
        end
        mpend = mvq && !c_vde;
        mvq = c_vde;
    endtask

    // capture inputs exactly as seen at the active edge
    always @(posedge clk) begin
        c_rst = rst_n;
        c_vde = vde;
        c_raw[0][0] = left;
        c_raw[0][1] = right;
        c_raw[0][2] = up;
        c_raw[0][3] = down;
        c_raw[1][0] = b_left;
        c_raw[1][1] = 1'b1;
        c_raw[1][2] = 1'b1;
        c_raw[1][3] = 1'b1;
    end

    // scoreboard: compare every cycle on the falling edge
    always @(negedge clk) begin
        if (!c_rst) model_reset();
        else model_step();
        if (!rst_n) model_reset();
        check("x_a", int'(x_a), mx[0]);
        check("y_a", int'(y_a), my[0]);
        check("upd_a", int'(upd_a), int'(mupd[0]));
        check("mov_a", int'(mov_a), int'(mmov[0]));
        check("x_b", int'(x_b), mx[1]);
        check("y_b", int'(y_b), my[1]);
        check("upd_b", int'(upd_b), int'(mupd[1]));
        check("mov_b", int'(mov_b), int'(mmov[1]));
        if (rst_n && c_rst && ((int'(x_a) != px[0]) || (int'(y_a) != py[0])))
            check("no_tear_vde", int'(c_vde), 0);
        px[0] = int'(x_a);
        py[0] = int'(y_a);
        if (upd_a) upd_cnt++;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        rst_n = 1'b0; vde = 1'b0;
        left = 1'b1; right = 1'b1; up = 1'b1; down = 1'b1;
        b_left = 1'b0;
        tick(3);
        check("rst_x", int'(x_a), 380);
        check("rst_y", int'(y_a), 220);
        check("rst_upd", int'(upd_a), 0);
        check("rst_mov", int'(mov_a), 0);

        // reset released during blanking: no tick
        rst_n = 1'b1;
        tick(10);
        check("no_tick_after_rst", upd_cnt, 0);

        // 3-cycle glitch on right is rejected
        vde = 1'b1;
        tick(4);
        right = 1'b0;
        tick(3);
        right = 1'b1;
        tick(10);
        vde = 1'b0;
        @(negedge clk); check("glitch_upd0", int'(upd_a), 0);
        @(negedge clk); check("glitch_upd1", int'(upd_a), 0);
        @(negedge clk);
        check("glitch_upd2", int'(upd_a), 1);
        check("glitch_x", int'(x_a), 380);
        check("b_left_to0", int'(x_b), 0);
        tick(3);

        // stable right press, then one frame tick
        vde = 1'b1;
        tick(3);
        right = 1'b0;
        tick(8);
        vde = 1'b0;
        @(negedge clk); check("lat_upd0", int'(upd_a), 0);
        @(negedge clk); check("lat_upd1", int'(upd_a), 0);
        @(negedge clk);
        check("lat_upd2", int'(upd_a), 1);
        check("lat_x", int'(x_a), 384);
        check("lat_mov", int'(mov_a), 1);
        @(negedge clk); check("lat_upd3", int'(upd_a), 0);
        right = 1'b1;
        tick(2);
        vde = 1'b1;
        tick(8);

        // right clamp at 760
        right = 1'b0;
        tick(8);
        repeat (110) frame(4, 3);
        check("clamp_right", int'(x_a), 760);
        check("clamp_right_mov", int'(mov_a), 0);

        // left clamp at 0
        right = 1'b1;
        left = 1'b0;
        tick(8);
        repeat (200) frame(4, 3);
        check("clamp_left", int'(x_a), 0);

        // left+right cancel, down moves to 440
        right = 1'b0;
        down = 1'b0;
        tick(8);
        repeat (60) frame(4, 3);
        check("conflict_x", int'(x_a), 0);
        check("clamp_down", int'(y_a), 440);
        check("clamp_down_mov", int'(mov_a), 0);

        // full-size frames, buttons changed mid active video
        left = 1'b1; right = 1'b1; down = 1'b1;
        tick(8);
        base = upd_cnt;
        for (int f = 0; f < 3; f++) begin
            vde = 1'b1;
            tick(240);
            case (f)
                0: up = 1'b0;
                1: begin up = 1'b1; right = 1'b0; end
                default: right = 1'b1;
            endcase
            tick(240);
            vde = 1'b0;
            tick(45);
        end
        check("one_upd_per_frame", upd_cnt - base, 3);
        check("frames_x", int'(x_a), 4);
        check("frames_y", int'(y_a), 436);

        // asynchronous reset mid-frame
        vde = 1'b1;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("async_rst_x", int'(x_a), 380);
        check("async_rst_y", int'(y_a), 220);
        check("async_rst_upd", int'(upd_a), 0);
        check("async_rst_xb", int'(x_b), 2);
        tick(3);
        rst_n = 1'b1;
        tick(10);
        vde = 1'b0;
        tick(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
